// File: rtl/display_scanner.sv
// Four-digit multiplexed seven-segment scanner: advances one digit per div_clk rising edge,
// blanks for one cycle between digits and latches a new frame only at the digit 3 -> 0 wrap.
module display_scanner #(
    parameter int BLANK_LEADING = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        div_clk,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  digit_sel
);

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } scan_state_t;

    scan_state_t state_r;

    logic        sync1_r;
    logic        sync2_r;
    logic        hist_r;
    logic        tick_s;

    logic [15:0] shadow_val_r;
    logic [3:0]  shadow_dp_r;
    logic [3:0]  shadow_en_r;

    logic [1:0]  digit_sel_r;
    logic [3:0]  anode_r;
    logic [6:0]  seg_r;
    logic        dp_r;

    logic [3:0]  nibble_s;
    logic        lead_zero_s;
    logic        lit_s;
    logic [3:0]  anode_sel_s;
    logic [6:0]  seg_dec_s;

    // Standard active-low hex decode, bit0 = segment a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign tick_s = sync2_r & ~hist_r;

    // Decode what the current digit would show from the frozen frame.
    always_comb begin
        nibble_s    = shadow_val_r[{digit_sel_r, 2'b00} +: 4];
        lead_zero_s = 1'b0;
        case (digit_sel_r)
            2'd0:    lead_zero_s = 1'b0;
            2'd1:    lead_zero_s = (shadow_val_r[15:4] == 12'h000);
            2'd2:    lead_zero_s = (shadow_val_r[15:8] == 8'h00);
            2'd3:    lead_zero_s = (shadow_val_r[15:12] == 4'h0);
            default: lead_zero_s = 1'b0;
        endcase
        if (shadow_en_r[digit_sel_r] && !((BLANK_LEADING != 0) && lead_zero_s)) begin
            lit_s = 1'b1;
        end else begin
            lit_s = 1'b0;
        end
        anode_sel_s = ~(4'b0001 << digit_sel_r);
        seg_dec_s   = hex_to_seg(nibble_s);
    end

    // Bring div_clk into the clock domain and keep one history bit for edge detection.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            hist_r  <= 1'b0;
        end else begin
            sync1_r <= div_clk;
            sync2_r <= sync1_r;
            hist_r  <= sync2_r;
        end
    end

    // Scan FSM: a tick always advances and blanks; the following quiet cycle lights the digit.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r      <= SHOW;
            digit_sel_r  <= 2'd3;
            anode_r      <= 4'hF;
            seg_r        <= 7'h7F;
            dp_r         <= 1'b1;
            shadow_val_r <= 16'h0000;
            shadow_dp_r  <= 4'h0;
            shadow_en_r  <= 4'hF;
        end else if (tick_s) begin
            state_r     <= BLANK;
            digit_sel_r <= digit_sel_r + 2'd1;
            anode_r     <= 4'hF;
            seg_r       <= 7'h7F;
            dp_r        <= 1'b1;
            if (digit_sel_r == 2'd3) begin
                shadow_val_r <= value;
                shadow_dp_r  <= dp_in;
                shadow_en_r  <= digit_en;
            end
        end else begin
            case (state_r)
                BLANK: begin
                    state_r <= SHOW;
                    if (lit_s) begin
                        anode_r <= anode_sel_s;
                        seg_r   <= seg_dec_s;
                        dp_r    <= ~shadow_dp_r[digit_sel_r];
                    end else begin
                        anode_r <= 4'hF;
                        seg_r   <= 7'h7F;
                        dp_r    <= 1'b1;
                    end
                end
                SHOW: begin
                    state_r <= SHOW;
                end
                default: begin
                    state_r <= SHOW;
                    anode_r <= 4'hF;
                    seg_r   <= 7'h7F;
                    dp_r    <= 1'b1;
                end
            endcase
        end
    end

    assign anode     = anode_r;
    assign seg       = seg_r;
    assign dp        = dp_r;
    assign digit_sel = digit_sel_r;

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner: one instance without and one with leading-zero blanking.
module tb_display_scanner;

    logic        clock = 1'b0;
    logic        reset;
    logic        div_clk;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;

    logic [3:0]  anode_a, anode_b;
    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic [1:0]  sel_a, sel_b;

    int total = 0;
    int bad   = 0;

    logic [15:0] sh_val;
    logic [3:0]  sh_dp;
    logic [3:0]  sh_en;
    logic [1:0]  exp_sel;
    logic [27:0] sb_q[$];

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    display_scanner #(.BLANK_LEADING(0)) dut_a (
        .clock(clock), .reset(reset), .div_clk(div_clk), .value(value), .dp_in(dp_in),
        .digit_en(digit_en), .anode(anode_a), .seg(seg_a), .dp(dp_a), .digit_sel(sel_a));

    display_scanner #(.BLANK_LEADING(1)) dut_b (
        .clock(clock), .reset(reset), .div_clk(div_clk), .value(value), .dp_in(dp_in),
        .digit_en(digit_en), .anode(anode_b), .seg(seg_b), .dp(dp_b), .digit_sel(sel_b));

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] dark(input logic [1:0] d);
        return {4'hF, 7'h7F, 1'b1, d};
    endfunction

    function automatic logic [13:0] exp_show(input int bl, input logic [1:0] d);
        logic [3:0] nib;
        logic       lz;
        logic       lit;
        nib = 4'((sh_val >> (d * 4)));
        lz  = (d != 2'd0) && ((sh_val >> (d * 4)) == 16'h0000);
        lit = sh_en[d] && !(bl == 1 && lz);
        if (lit) return {~(4'b0001 << d), seg_tab[nib], ~sh_dp[d], d};
        return dark(d);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
        check_eq("onehot_a", 32'($countones(~anode_a) <= 1), 32'd1);
        check_eq("onehot_b", 32'($countones(~anode_b) <= 1), 32'd1);
    endtask

    task automatic model_reset();
        exp_sel = 2'd3;
        sh_val  = 16'h0000;
        sh_dp   = 4'h0;
        sh_en   = 4'hF;
    endtask

    task automatic model_tick();
        exp_sel = exp_sel + 2'd1;
        if (exp_sel == 2'd0) begin
            sh_val = value;
            sh_dp  = dp_in;
            sh_en  = digit_en;
        end
        sb_q.push_back({exp_show(0, exp_sel), exp_show(1, exp_sel)});
    endtask

    task automatic check_dark(input string tag);
        check_eq({tag, "/dark_a"}, {18'h0, anode_a, seg_a, dp_a, sel_a}, {18'h0, dark(exp_sel)});
        check_eq({tag, "/dark_b"}, {18'h0, anode_b, seg_b, dp_b, sel_b}, {18'h0, dark(exp_sel)});
    endtask

    task automatic pop_check(input string tag);
        logic [27:0] e;
        if (sb_q.size() == 0) begin
            check_eq({tag, "/sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_eq({tag, "/show_a"}, {18'h0, anode_a, seg_a, dp_a, sel_a}, {18'h0, e[27:14]});
            check_eq({tag, "/show_b"}, {18'h0, anode_b, seg_b, dp_b, sel_b}, {18'h0, e[13:0]});
        end
    endtask

    // div_clk rises before edge 1; digit_sel moves at edge 3, digit lights at edge 4.
    task automatic do_tick(input string tag);
        div_clk = 1'b1;
        model_tick();
        step();
        step();
        step();
        check_dark(tag);
        div_clk = 1'b0;
        step();
        pop_check(tag);
        step();
        step();
    endtask

    initial begin
        reset    = 1'b0;
        div_clk  = 1'b0;
        value    = 16'h0000;
        dp_in    = 4'h0;
        digit_en = 4'hF;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            div_clk = ~div_clk;
            step();
            check_dark("reset");
        end
        div_clk = 1'b0;
        step();
        reset = 1'b1;
        step();
        step();
        check_dark("post_reset_idle");

        value = 16'h1234;
        for (int i = 0; i < 4; i++) do_tick("h1234");

        value = 16'h0050;
        for (int i = 0; i < 4; i++) do_tick("h0050");

        value = 16'h0000;
        for (int i = 0; i < 4; i++) do_tick("zero");

        value = 16'h1111;
        do_tick("tear0");
        do_tick("tear1");
        value = 16'h2222;
        do_tick("tear2");
        do_tick("tear3");
        do_tick("tear_wrap");

        // Two ticks separated by a single quiet cycle.
        div_clk = 1'b1;
        model_tick();
        step();
        div_clk = 1'b0;
        step();
        div_clk = 1'b1;
        step();
        check_dark("dbl1");
        div_clk = 1'b0;
        step();
        pop_check("dbl1");
        model_tick();
        step();
        check_dark("dbl2");
        step();
        pop_check("dbl2");
        step();
        step();

        value = 16'h0A80;
        reset = 1'b0;
        step();
        model_reset();
        check_dark("mid_reset");
        reset = 1'b1;
        step();
        check_dark("mid_reset_idle");
        for (int i = 0; i < 4; i++) do_tick("h0a80");

        value    = 16'hF005;
        dp_in    = 4'b1010;
        digit_en = 4'b1101;
        for (int i = 0; i < 4; i++) do_tick("hf005");

        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
